// File: rtl/fb_scanout_if.sv
// fb_scanout_if: frame-buffer read port; the scanout engine is master, memory is slave.
interface fb_scanout_if #(
   parameter int ADDR_W = 18
) ();
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [11:0]       rd_data;
   modport master (output rd_en, output rd_addr, input rd_data);
   modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: double-buffered frame-buffer scanout with a fixed-latency read pipeline.
// Page flips are deferred to the next vsync rising edge so a frame never mixes pages.
module fb_scanout #(
   parameter int POS_DIV = 9,
   parameter int FB_COLS = 320,
   parameter int FB_ROWS = 240,
   parameter int ADDR_W  = 18,
   parameter int MEM_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [POS_DIV-1:0] pos_x_div,
   input  logic [POS_DIV-1:0] pos_y_div,
   input  logic               active,
   input  logic               i_hsync,
   input  logic               i_vsync,
   fb_scanout_if.master       mem,
   input  logic               swap_req,
   output logic               swap_ack,
   output logic               page,
   output logic [3:0]         o_red,
   output logic [3:0]         o_green,
   output logic [3:0]         o_blue,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_active
);
   typedef enum logic {IDLE, PENDING} state_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [POS_DIV:0]  pos_t;
   localparam addr_t PAGE_OFS = addr_t'(FB_COLS * FB_ROWS);
   localparam addr_t COLS_A   = addr_t'(FB_COLS);
   localparam pos_t  COLS_P   = pos_t'(FB_COLS);
   localparam pos_t  ROWS_P   = pos_t'(FB_ROWS);
   state_t      state_q, state_d;
   logic        vs_prev_q, vs_rise, ack_d, swap_ack_q, page_q;
   logic        en_d;
   addr_t       addr_d, addr_q;
   logic [3:0]  s1_q;
   logic [3:0]  dl_q [MEM_LAT];
   logic [11:0] rgb_q;
   logic [2:0]  sync_q;
   // Previous vsync resets high so a level already high at release is not an edge.
   assign vs_rise = i_vsync & ~vs_prev_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vs_prev_q  <= 1'b1;
         swap_ack_q <= 1'b0;
         page_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vs_prev_q  <= i_vsync;
         swap_ack_q <= ack_d;
         page_q     <= page_q ^ ack_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (swap_req ? PENDING : IDLE) : (vs_rise ? IDLE : PENDING);
   end
   always_comb begin
      ack_d = (state_q == PENDING) & vs_rise;
   end
   always_comb begin
      en_d   = active & ({1'b0, pos_x_div} < COLS_P) & ({1'b0, pos_y_div} < ROWS_P);
      addr_d = (page_q ? PAGE_OFS : '0) + addr_t'(pos_y_div) * COLS_A + addr_t'(pos_x_div);
   end
   // Qualifier and syncs ride a MEM_LAT-deep line behind stage 1 to meet the returning data.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         s1_q   <= '0;
         for (int i = 0; i < MEM_LAT; i++) dl_q[i] <= '0;
         rgb_q  <= '0;
         sync_q <= '0;
      end else begin
         addr_q  <= addr_d;
         s1_q    <= {en_d, active, i_hsync, i_vsync};
         dl_q[0] <= s1_q;
         for (int i = 1; i < MEM_LAT; i++) dl_q[i] <= dl_q[i-1];
         rgb_q   <= dl_q[MEM_LAT-1][3] ? mem.rd_data : 12'h000;
         sync_q  <= dl_q[MEM_LAT-1][2:0];
      end
   end
   assign mem.rd_en                 = s1_q[3];
   assign mem.rd_addr               = addr_q;
   assign {o_red, o_green, o_blue}  = rgb_q;
   assign {o_active, o_hsync, o_vsync} = sync_q;
   assign swap_ack                  = swap_ack_q;
   assign page                      = page_q;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed stimulus with queued expectations checked by a cycle-stamped monitor.
module tb_fb_scanout;
   localparam int L = 3;
   logic       clk = 1'b0, rst = 1'b1;
   logic [8:0] pos_x_div = '0, pos_y_div = '0;
   logic       active = 1'b0, i_hsync = 1'b0, i_vsync = 1'b1, swap_req = 1'b0;
   logic       swap_ack, page, o_hsync, o_vsync, o_active;
   logic [3:0] o_red, o_green, o_blue;
   logic [11:0] m0, m1;
   int cyc = 0, n_tests = 0, n_fail = 0;
   bit m_prev = 1'b1, m_pend = 1'b0, m_page = 1'b0;
   typedef struct {int due; logic [18:0] v;} ent_t;
   ent_t rq[$], aq[$], oq[$];

   fb_scanout_if #(.ADDR_W(18)) mif ();
   fb_scanout #(.POS_DIV(9), .FB_COLS(320), .FB_ROWS(240), .ADDR_W(18), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst), .pos_x_div(pos_x_div), .pos_y_div(pos_y_div),
      .active(active), .i_hsync(i_hsync), .i_vsync(i_vsync), .mem(mif),
      .swap_req(swap_req), .swap_ack(swap_ack), .page(page),
      .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
      .o_hsync(o_hsync), .o_vsync(o_vsync), .o_active(o_active));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] mem_word(logic [17:0] a);
      return a[11:0] ^ 12'h999;
   endfunction

   // Two-stage memory: rd_data valid two cycles after rd_en; 0xFFF when not read.
   always @(posedge clk) begin
      m0 <= mif.rd_en ? mem_word(mif.rd_addr) : 12'hFFF;
      m1 <= m0;
   end
   assign mif.rd_data = m1;

   task automatic chk(string nm, logic [18:0] act, logic [18:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      while (rq.size() > 0 && rq[0].due <= cyc) begin
         ent_t e;
         e = rq.pop_front();
         chk("rd_en", 19'(mif.rd_en), 19'(e.v[18]));
         if (e.v[18]) chk("rd_addr", 19'(mif.rd_addr), 19'(e.v[17:0]));
      end
      while (aq.size() > 0 && aq[0].due <= cyc) begin
         ent_t e;
         e = aq.pop_front();
         chk("swap_ack_page", 19'({swap_ack, page}), e.v);
      end
      while (oq.size() > 0 && oq[0].due <= cyc) begin
         ent_t e;
         e = oq.pop_front();
         chk("pixel_out", 19'({o_active, o_hsync, o_vsync, o_red, o_green, o_blue}), e.v);
      end
   end

   task automatic drive(int x, int y, bit act, bit hs, bit vs, bit req);
      ent_t e;
      bit en, rise, ack;
      logic [17:0] addr;
      @(negedge clk);
      rst = 1'b0;
      pos_x_div = 9'(x); pos_y_div = 9'(y);
      active = act; i_hsync = hs; i_vsync = vs; swap_req = req;
      en   = act && x < 320 && y < 240;
      addr = 18'((m_page ? 76800 : 0) + y * 320 + x);
      e.due = cyc + 1; e.v = {en, en ? addr : 18'h0};
      rq.push_back(e);
      e.due = cyc + 1 + L; e.v = {4'b0, act, hs, vs, en ? mem_word(addr) : 12'h000};
      oq.push_back(e);
      rise   = vs && !m_prev;
      ack    = m_pend && rise;
      m_pend = m_pend ? !rise : req;
      m_page = m_page ^ ack;
      m_prev = vs;
      e.due = cyc + 1; e.v = {17'b0, ack, m_page};
      aq.push_back(e);
   endtask

   task automatic drain(string nm);
      repeat (L + 4) @(negedge clk);
      chk(nm, 19'(rq.size() + aq.size() + oq.size()), 19'd0);
   endtask

   // Reset with vsync held high and a swap request that must be discarded.
   task automatic do_reset();
      drain("queues_drained");
      rst = 1'b1; swap_req = 1'b1; i_vsync = 1'b1; active = 1'b1; i_hsync = 1'b1;
      pos_x_div = 9'd5; pos_y_div = 9'd3;
      @(negedge clk);
      swap_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rd", 19'({mif.rd_en, mif.rd_addr}), 19'd0);
      chk("rst_swap", 19'({swap_ack, page}), 19'd0);
      chk("rst_out", 19'({o_active, o_hsync, o_vsync, o_red, o_green, o_blue}), 19'd0);
      rq.delete(); aq.delete(); oq.delete();
      m_prev = 1'b1; m_pend = 1'b0; m_page = 1'b0;
   endtask

   initial begin
      logic [7:0] hp;
      hp = 8'b1011_0010;
      do_reset();
      for (int i = 0; i < 8; i++) drive(0, 0, 0, hp[i], 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(5, 3, 1, 0, 0, 0);
      drive(320, 3, 1, 1, 0, 0);
      drive(5, 240, 1, 0, 0, 0);
      drive(319, 239, 1, 1, 0, 0);
      drive(10, 10, 1, 0, 0, 1);
      drive(11, 10, 1, 0, 0, 0);
      drive(12, 10, 1, 0, 0, 1);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 0);
      drive(0, 0, 1, 0, 1, 0);
      drive(7, 2, 1, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 1, 1);
      drive(2, 1, 1, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(3, 1, 1, 0, 1, 0);
      for (int f = 0; f < 4; f++) begin
         drive(f, 0, 1, 1, 0, 0);
         drive(f, 1, 1, 0, 1, 0);
      end
      drive(4, 4, 1, 0, 0, 1);
      drive(4, 4, 1, 0, 0, 0);
      do_reset();
      drive(0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(5, 3, 1, 1, 1, 0);
      drive(319, 0, 1, 0, 1, 0);
      drain("final_drain");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
